unidade_divisao: RTL and testbench
==================================

UNIDADE_DIVISAO -- requirements
Module: unidade_divisao

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, legal range 4..64.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port Dividend  input  WIDTH  numerator; captured on the accepting edge.
REQ-006 SHALL have port Divisor  input  WIDTH  denominator; captured on the accepting edge.
REQ-007 SHALL have port Busy  output  1  high while a division is in progress (CALC state).
REQ-008 SHALL have port Done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port Quotient  output  WIDTH  result of Dividend / Divisor.
REQ-010 SHALL have port Remainder  output  WIDTH  result of Dividend mod Divisor; feeds register R30.
REQ-011 SHALL have port DivZero  output  1  high with Done when Divisor was zero.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIN.
- IDLE -> CALC on Start=1 with nonzero Divisor.
- IDLE -> FIN on Start=1 with zero Divisor.
- CALC -> FIN after WIDTH iterations.
- FIN -> IDLE unconditionally.
REQ-013 SHALL use restoring division, one quotient bit per cycle; iteration counter width clog2(WIDTH+1).
REQ-014 SHALL assert Done in the cycle after the (WIDTH+1)th rising edge following the accepting edge; with WIDTH=32, Done is high after edge 33.
REQ-015 SHALL hold Done for exactly one cycle.
REQ-016 SHALL hold Quotient, Remainder and DivZero stable from the Done cycle until the next accepted Start.
REQ-017 SHALL ignore Start in CALC and FIN; operands are not re-captured.
REQ-018 SHALL, on a zero Divisor: set Quotient to all ones, set Remainder to Dividend and set DivZero=1, with Done one cycle after acceptance.
REQ-019 SHALL satisfy Quotient*Divisor+Remainder==Dividend and Remainder<Divisor (unsigned) for every nonzero Divisor.
REQ-020 SHALL accept Start in the IDLE cycle directly after FIN, allowing back-to-back operations.
REQ-021 SHALL keep Busy=0 in IDLE and FIN.

Reset
REQ-022 SHALL, on Reset=0 at any time (including mid-CALC), abort the operation and force IDLE.
REQ-023 SHALL, on Reset=0, clear Busy, Done, DivZero, Quotient, Remainder and the counter to 0.
REQ-024 SHALL not produce a Done pulse for an operation aborted by reset.

Configuration
REQ-025 SHALL use macro DIV_SIGNED_EN to enable signed division.
- Defined: adds input port Signed (1 bit), sampled with Start.
- Signed=1: operands are two's complement, the quotient truncates toward zero and the Remainder takes the sign of the Dividend.
- Latency is unchanged in signed mode.
REQ-026 SHALL, when DIV_SIGNED_EN is undefined, have no Signed port and perform unsigned division only.

Structure
REQ-027 SHALL take the FSM state enum and the default WIDTH constant from shared package div_pkg.
REQ-028 SHALL place operand abs/negation and result sign correction in one sub-module, ajuste_sinal, instantiated only under DIV_SIGNED_EN.

Verification
REQ-029 SHALL verify with WIDTH=32: 100/7 -> Quotient=14, Remainder=2, DivZero=0, Done a single pulse after edge 33, Busy high for 32 cycles.
REQ-030 SHALL verify 5/0 -> Quotient=FFFFFFFF, Remainder=5, DivZero=1, Done one cycle after acceptance, Busy never high.
REQ-031 SHALL verify that pulsing Start with 9/3 while 100/7 is busy still gives Quotient=14, Remainder=2, with only one Done.
REQ-032 SHALL verify that Reset=0 at iteration 10 of FFFFFFFF/1 returns IDLE with all outputs 0 and no Done.
REQ-033 SHALL verify that with DIV_SIGNED_EN and Signed=1, -7/2 -> Quotient=FFFFFFFD, Remainder=FFFFFFFF.
REQ-034 SHALL verify that 10/3, then Start in the IDLE cycle after FIN with 20/6, returns 3/1 then 3/2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider: FSM state encoding and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } divState_t;

endpackage

// File: rtl/ajuste_sinal.sv
// Signed-mode helper: operand magnitudes on capture and sign restoration of the raw results.
// Combinational, no latency; only present when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module ajuste_sinal
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             signedMode,
  input  logic [WIDTH-1:0] dividendIn,
  input  logic [WIDTH-1:0] divisorIn,
  output logic [WIDTH-1:0] dividendMag,
  output logic [WIDTH-1:0] divisorMag,
  output logic             negQuo,
  output logic             negRem,
  input  logic             quoNeg,
  input  logic             remNeg,
  input  logic [WIDTH-1:0] quoRaw,
  input  logic [WIDTH-1:0] remRaw,
  output logic [WIDTH-1:0] quoFix,
  output logic [WIDTH-1:0] remFix
);

  logic dividendSgn;
  logic divisorSgn;

  assign dividendSgn = signedMode & dividendIn[WIDTH-1];
  assign divisorSgn  = signedMode & divisorIn[WIDTH-1];

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign dividendMag = dividendSgn ? -dividendIn : dividendIn;
  assign divisorMag  = divisorSgn  ? -divisorIn  : divisorIn;

  // Truncation toward zero: quotient negative on sign mismatch, remainder follows the dividend.
  assign negQuo = dividendSgn ^ divisorSgn;
  assign negRem = dividendSgn;

  assign quoFix = quoNeg ? -quoRaw : quoRaw;
  assign remFix = remNeg ? -remRaw : remRaw;

endmodule
`endif

// File: rtl/unidade_divisao.sv
// Iterative restoring divider, one quotient bit per cycle; DIV_SIGNED_EN adds a Signed input.
// Done pulses WIDTH+1 edges after acceptance (1 edge for a zero divisor); Start ignored unless IDLE.
module unidade_divisao
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
`ifdef DIV_SIGNED_EN
  input  logic             Signed,
`endif
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  divState_t        state;
  divState_t        nextState;
  logic [CNT_W-1:0] iterCnt;
  logic [WIDTH-1:0] quoW;
  logic [WIDTH-1:0] remW;
  logic [WIDTH-1:0] divW;
  logic             zeroFlag;

  logic             divisorZero;
  logic             lastIter;
  logic [WIDTH:0]   remShift;
  logic             fits;
  logic [WIDTH-1:0] remNext;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] quoOut;
  logic [WIDTH-1:0] remOut;

  assign divisorZero = (Divisor == '0);
  assign lastIter    = (iterCnt == CNT_W'(WIDTH - 1));

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign remShift = {remW, quoW[WIDTH-1]};
  assign fits     = (remShift >= {1'b0, divW});
  assign remNext  = fits ? WIDTH'(remShift - {1'b0, divW}) : remShift[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic capNegQ;
  logic capNegR;
  logic negQ;
  logic negR;

  ajuste_sinal #(
    .WIDTH(WIDTH)
  ) uAjusteSinal (
    .signedMode (Signed),
    .dividendIn (Dividend),
    .divisorIn  (Divisor),
    .dividendMag(opA),
    .divisorMag (opB),
    .negQuo     (capNegQ),
    .negRem     (capNegR),
    .quoNeg     (negQ),
    .remNeg     (negR),
    .quoRaw     (quoW),
    .remRaw     (remW),
    .quoFix     (quoOut),
    .remFix     (remOut)
  );

  // Zero-divisor results are loaded pre-formatted, so no sign correction applies to them.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      negQ <= 1'b0;
      negR <= 1'b0;
    end else if (state == IDLE && Start) begin
      negQ <= capNegQ & ~divisorZero;
      negR <= capNegR & ~divisorZero;
    end
  end
`else
  assign opA    = Dividend;
  assign opB    = Divisor;
  assign quoOut = quoW;
  assign remOut = remW;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          nextState = divisorZero ? FIN : CALC;
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (lastIter) begin
          nextState = FIN;
        end
      end
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      iterCnt   <= '0;
      quoW      <= '0;
      remW      <= '0;
      divW      <= '0;
      zeroFlag  <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            iterCnt  <= '0;
            divW     <= opB;
            zeroFlag <= divisorZero;
            if (divisorZero) begin
              quoW <= '1;
              remW <= Dividend;
            end else begin
              quoW <= opA;
              remW <= '0;
            end
          end
        end
        CALC: begin
          quoW    <= {quoW[WIDTH-2:0], fits};
          remW    <= remNext;
          iterCnt <= iterCnt + 1'b1;
        end
        // Results are published on the FIN exit edge, so they change only once per operation.
        FIN: begin
          Quotient  <= quoOut;
          Remainder <= remOut;
          DivZero   <= zeroFlag;
          Done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_divisao.sv
// Directed bench for unidade_divisao (WIDTH=32); signed vector included when DIV_SIGNED_EN is defined.
module tb_unidade_divisao;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivZero;
`ifdef DIV_SIGNED_EN
  logic        sgn;
`endif

  int          nErr;
  int          nChecks;
  int          doneCnt;
  int          busyCnt;
  int          eDone   [2];
  logic [31:0] qDone   [2];
  logic [31:0] rDone   [2];
  logic        zDone   [2];

  unidade_divisao #(
    .WIDTH(32)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
`ifdef DIV_SIGNED_EN
    .Signed   (sgn),
`endif
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivZero  (DivZero)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge 0 is the accepting edge; every edge up to 'span' is sampled 1 time unit after it.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input int span,
                       input int injectEdge, input logic chain,
                       input logic [31:0] ca, input logic [31:0] cb);
    @(negedge CLK);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    doneCnt  = 0;
    busyCnt  = 0;
    for (int i = 0; i < 2; i++) begin
      eDone[i] = -1;
      qDone[i] = '0;
      rDone[i] = '0;
      zDone[i] = 1'b0;
    end
    for (int e = 0; e <= span; e++) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
      if (Busy) busyCnt++;
      if (Done) begin
        if (doneCnt < 2) begin
          eDone[doneCnt] = e;
          qDone[doneCnt] = Quotient;
          rDone[doneCnt] = Remainder;
          zDone[doneCnt] = DivZero;
        end
        doneCnt++;
        if (chain && doneCnt == 1) begin
          Dividend = ca;
          Divisor  = cb;
          Start    = 1'b1;
        end
      end
      if (e == injectEdge) begin
        Dividend = 32'd9;
        Divisor  = 32'd3;
        Start    = 1'b1;
      end
    end
  endtask

  initial begin
    nErr     = 0;
    nChecks  = 0;
    Reset    = 1'b0;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
`ifdef DIV_SIGNED_EN
    sgn      = 1'b0;
`endif

    @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_quo", Quotient, 0);
    chk("rst_rem", Remainder, 0);
    chk("rst_dz", DivZero, 0);
    Reset = 1'b1;
    @(negedge CLK);
    chk("idle_busy", Busy, 0);

    // 100/7
    runOp(32'd100, 32'd7, 40, -1, 1'b0, '0, '0);
    chk("d100_7_ndone", doneCnt, 1);
    chk("d100_7_edge", eDone[0], 33);
    chk("d100_7_quo", qDone[0], 32'd14);
    chk("d100_7_rem", rDone[0], 32'd2);
    chk("d100_7_dz", zDone[0], 0);
    chk("d100_7_busy", busyCnt, 32);
    chk("d100_7_hold_quo", Quotient, 32'd14);
    chk("d100_7_hold_rem", Remainder, 32'd2);

    // 5/0
    runOp(32'd5, 32'd0, 10, -1, 1'b0, '0, '0);
    chk("d5_0_ndone", doneCnt, 1);
    chk("d5_0_edge", eDone[0], 1);
    chk("d5_0_quo", qDone[0], 32'hFFFF_FFFF);
    chk("d5_0_rem", rDone[0], 32'd5);
    chk("d5_0_dz", zDone[0], 1);
    chk("d5_0_busy", busyCnt, 0);

    // 100/7 with a 9/3 Start pulse while busy
    runOp(32'd100, 32'd7, 45, 5, 1'b0, '0, '0);
    chk("inj_ndone", doneCnt, 1);
    chk("inj_edge", eDone[0], 33);
    chk("inj_quo", qDone[0], 32'd14);
    chk("inj_rem", rDone[0], 32'd2);
    chk("inj_dz", zDone[0], 0);

    // Larger dividend and divisor above dividend
    runOp(32'hDEAD_BEEF, 32'h10, 36, -1, 1'b0, '0, '0);
    chk("dbeef_quo", qDone[0], 32'h0DEA_DBEE);
    chk("dbeef_rem", rDone[0], 32'hF);
    runOp(32'd3, 32'd10, 36, -1, 1'b0, '0, '0);
    chk("d3_10_quo", qDone[0], 32'd0);
    chk("d3_10_rem", rDone[0], 32'd3);

    // Back-to-back: 10/3 then 20/6 started in the Done cycle
    runOp(32'd10, 32'd3, 70, -1, 1'b1, 32'd20, 32'd6);
    chk("b2b_ndone", doneCnt, 2);
    chk("b2b_quo0", qDone[0], 32'd3);
    chk("b2b_rem0", rDone[0], 32'd1);
    chk("b2b_edge1", eDone[1], 67);
    chk("b2b_quo1", qDone[1], 32'd3);
    chk("b2b_rem1", rDone[1], 32'd2);

    // Reset at iteration 10 of FFFFFFFF/1
    runOp(32'hFFFF_FFFF, 32'd1, 10, -1, 1'b0, '0, '0);
    chk("abort_busy_pre", Busy, 1);
    Reset = 1'b0;
    #2;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_quo", Quotient, 0);
    chk("abort_rem", Remainder, 0);
    chk("abort_dz", DivZero, 0);
    @(negedge CLK);
    Reset   = 1'b1;
    doneCnt = 0;
    busyCnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge CLK);
      #1;
      if (Done) doneCnt++;
      if (Busy) busyCnt++;
    end
    chk("abort_no_done", doneCnt, 0);
    chk("abort_idle", busyCnt, 0);

`ifdef DIV_SIGNED_EN
    sgn = 1'b1;
    runOp(32'hFFFF_FFF9, 32'd2, 36, -1, 1'b0, '0, '0);
    chk("sgn_edge", eDone[0], 33);
    chk("sgn_quo", qDone[0], 32'hFFFF_FFFD);
    chk("sgn_rem", rDone[0], 32'hFFFF_FFFF);
    sgn = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
